// File: rtl/uart_seg_parser_pkg.sv
// Shared definitions for the UART-to-7-segment entry parser: ASCII codes,
// FSM state encoding, display geometry and small decode helpers.
package uart_seg_parser_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 4;
    localparam int DATA_W     = NUM_DIGITS * BCD_W;
    localparam int CNT_W      = 3;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_DOT = 8'h2E;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    // Right-aligned enable mask with the lowest cnt bits set.
    function automatic logic [NUM_DIGITS-1:0] en_mask(input logic [CNT_W-1:0] cnt);
        logic [NUM_DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i < int'(cnt)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/uart_seg_parser_if.sv
// Byte-in / display-out bundle of the entry parser. The parser is the slave:
// it consumes UART bytes and drives the display fields and status pulses.
interface uart_seg_parser_if;
    import uart_seg_parser_pkg::*;

    logic [7:0]            pi_data;
    logic                  pi_flag;
    logic [DATA_W-1:0]     seg_data;
    logic [NUM_DIGITS-1:0] seg_en;
    logic [NUM_DIGITS-1:0] seg_point;
    logic                  seg_flag;
    logic                  err_flag;

    modport master (
        output pi_data, pi_flag,
        input  seg_data, seg_en, seg_point, seg_flag, err_flag
    );

    modport slave (
        input  pi_data, pi_flag,
        output seg_data, seg_en, seg_point, seg_flag, err_flag
    );

endinterface

// File: rtl/uart_timeout_cnt.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and fires a
// one-cycle expire pulse on the cycle the count sits at TIMEOUT_CYC-1.
module uart_timeout_cnt #(
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);
    // A clear in the same cycle wins, so a byte arriving on expiry keeps the entry.
    assign expire  = enable && !clear && at_last;

    // Cycle counter, wrapping to zero on expiry.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_seg_parser.sv
// Parses ASCII lines of up to six digits with an optional decimal point into
// BCD display fields; CR/LF commits, malformed or stale entries pulse err_flag.
module uart_seg_parser
    import uart_seg_parser_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    uart_seg_parser_if.slave bus
);

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     dig_q, dig_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] pnt_q, pnt_d;
    logic                  commit, reject;

    logic [DATA_W-1:0]     seg_data_q;
    logic [NUM_DIGITS-1:0] seg_en_q, seg_point_q;
    logic                  seg_flag_q, err_flag_q;

    logic                  expire;
    logic                  b_digit, b_eol, b_dot, full;
    logic [BCD_W-1:0]      b_val;

    assign b_digit = is_digit(bus.pi_data);
    assign b_eol   = is_eol(bus.pi_data);
    assign b_dot   = (bus.pi_data == ASCII_DOT);
    assign b_val   = bus.pi_data[BCD_W-1:0];
    assign full    = (cnt_q == CNT_W'(NUM_DIGITS));

    uart_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (bus.pi_flag || (state_q == ST_IDLE)),
        .enable  (state_q != ST_IDLE),
        .expire  (expire)
    );

    // State register.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (sys_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode from the incoming byte and the watchdog.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.pi_flag) begin
                    if (b_digit)     state_d = ST_COLLECT;
                    else if (!b_eol) state_d = ST_DISCARD;
                end
            end
            ST_COLLECT: begin
                if (bus.pi_flag) begin
                    if (b_digit)    state_d = full ? ST_DISCARD : ST_COLLECT;
                    else if (b_dot) state_d = (pnt_q != '0) ? ST_DISCARD : ST_COLLECT;
                    else if (b_eol) state_d = ST_IDLE;
                    else            state_d = ST_DISCARD;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (bus.pi_flag) begin
                    if (b_eol) state_d = ST_IDLE;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Working-buffer updates and commit/reject decisions per state.
    always_comb begin
        dig_d  = dig_q;
        cnt_d  = cnt_q;
        pnt_d  = pnt_q;
        commit = 1'b0;
        reject = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.pi_flag) begin
                    if (b_digit) begin
                        dig_d = {{(DATA_W-BCD_W){1'b0}}, b_val};
                        cnt_d = CNT_W'(1);
                        pnt_d = '0;
                    end else if (!b_eol) begin
                        reject = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (bus.pi_flag) begin
                    if (b_digit) begin
                        if (full) begin
                            reject = 1'b1;
                        end else begin
                            dig_d = {dig_q[DATA_W-BCD_W-1:0], b_val};
                            pnt_d = {pnt_q[NUM_DIGITS-2:0], 1'b0};
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (b_dot) begin
                        if (pnt_q != '0) reject = 1'b1;
                        else             pnt_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
                    end else if (b_eol) begin
                        commit = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (expire) begin
                    reject = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath, display and status-pulse registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dig_q       <= '0;
            cnt_q       <= '0;
            pnt_q       <= '0;
            seg_data_q  <= '0;
            seg_en_q    <= '0;
            seg_point_q <= '0;
            seg_flag_q  <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            dig_q      <= dig_d;
            cnt_q      <= cnt_d;
            pnt_q      <= pnt_d;
            seg_flag_q <= commit;
            err_flag_q <= reject;
            if (commit) begin
                seg_data_q  <= dig_q;
                seg_en_q    <= en_mask(cnt_q);
                seg_point_q <= pnt_q;
            end
        end
    end

    assign bus.seg_data  = seg_data_q;
    assign bus.seg_en    = seg_en_q;
    assign bus.seg_point = seg_point_q;
    assign bus.seg_flag  = seg_flag_q;
    assign bus.err_flag  = err_flag_q;

endmodule
